// File: rtl/cdb_pkg.sv
// Shared definitions for the common data bus: tag width, the "no station"
// tag value and the arbiter state encoding.
package cdb_pkg;

   localparam int TAG_W = 6;
   localparam logic [TAG_W-1:0] NO_RS = 6'b000000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } cdb_state_e;

   // Width of an index into a group of n requesters (never less than 1 bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// CDB arbitration bundle: requests and bus activity from the units, grants
// and bookkeeping outputs from the arbiter.
interface cdb_arbiter_if #(
   parameter int N_UNITS = 4,
   parameter int COUNT_W = 16
);
   import cdb_pkg::*;

   localparam int IDX_W = idx_width(N_UNITS);

   logic [N_UNITS-1:0] CDB_rts;
   logic               CDB_write;
   logic [TAG_W-1:0]   CDB_source;
   logic [N_UNITS-1:0] CDB_xmit;
   logic               bus_busy;
   logic [IDX_W-1:0]   grant_index;
   logic [TAG_W-1:0]   last_source;
   logic [COUNT_W-1:0] broadcasts;
   logic               error;

   // Arbiter side.
   modport master (
      input  CDB_rts, CDB_write, CDB_source,
      output CDB_xmit, bus_busy, grant_index, last_source, broadcasts, error
   );

   // Functional-unit side.
   modport slave (
      output CDB_rts, CDB_write, CDB_source,
      input  CDB_xmit, bus_busy, grant_index, last_source, broadcasts, error
   );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin selector: the first set request found scanning
// upward from ptr (wrapping) wins. ptr must be below N_UNITS.
module rr_pick
   import cdb_pkg::*;
#(
   parameter int N_UNITS = 4,
   parameter int IDX_W   = idx_width(N_UNITS)
) (
   input  logic [N_UNITS-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   index
);

   // Requests rotated so that bit k corresponds to unit (ptr + k) mod N_UNITS.
   logic [N_UNITS-1:0] rot;

   assign rot = N_UNITS'({req, req} >> ptr);

   // Scan from the far end downward so the lowest rotated position wins.
   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int k = N_UNITS - 1; k >= 0; k--) begin
         if (rot[k]) begin
            valid = 1'b1;
            if (int'(ptr) + k >= N_UNITS)
               index = IDX_W'(int'(ptr) + k - N_UNITS);
            else
               index = IDX_W'(int'(ptr) + k);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. Grants one functional unit at a time for a fixed
// broadcast window, leaves one turnaround cycle, and passively watches the
// bus to count broadcasts and flag grants that never wrote or wrote tag 0.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int N_UNITS     = 4,
   parameter int HOLD_CYCLES = 2,
   parameter int COUNT_W     = 16
) (
   input  logic          clock,
   input  logic          reset,
   cdb_arbiter_if.master bus
);

   localparam int IDX_W  = idx_width(N_UNITS);
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_UNITS - 1);

   cdb_state_e         state_q, state_d;
   logic [N_UNITS-1:0] xmit_q, xmit_d;
   logic [IDX_W-1:0]   gidx_q, gidx_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic               wrote_q, wrote_d;
   logic [TAG_W-1:0]   last_src_q, last_src_d;
   logic [COUNT_W-1:0] bcast_q, bcast_d;
   logic               err_q, err_d;

   logic               pick_vld;
   logic [IDX_W-1:0]   pick_idx;
   logic               take;

   rr_pick #(
      .N_UNITS (N_UNITS),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (bus.CDB_rts),
      .ptr   (ptr_q),
      .valid (pick_vld),
      .index (pick_idx)
   );

   // Next-state and next-output logic. The turnaround cycle (RELEASE) also
   // arbitrates, so back-to-back grants are exactly HOLD_CYCLES+1 apart with
   // a single idle bus cycle between them.
   always_comb begin
      state_d    = state_q;
      xmit_d     = xmit_q;
      gidx_d     = gidx_q;
      ptr_d      = ptr_q;
      hold_d     = hold_q;
      wrote_d    = wrote_q;
      last_src_d = last_src_q;
      bcast_d    = bcast_q;
      err_d      = 1'b0;
      take       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            take = pick_vld;
         end

         ST_GRANT: begin
            // Only the first write of a grant is recorded.
            if (bus.CDB_write && !wrote_q) begin
               wrote_d    = 1'b1;
               last_src_d = bus.CDB_source;
               if (bus.CDB_source == NO_RS)
                  err_d = 1'b1;
            end
            if (hold_q != '0) begin
               hold_d = hold_q - HOLD_W'(1);
            end else begin
               xmit_d  = '0;
               ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + IDX_W'(1);
               state_d = ST_RELEASE;
            end
         end

         ST_RELEASE: begin
            if (wrote_q)
               bcast_d = bcast_q + COUNT_W'(1);
            else
               err_d = 1'b1;
            state_d = ST_IDLE;
            take    = pick_vld;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (take) begin
         xmit_d  = {{(N_UNITS-1){1'b0}}, 1'b1} << pick_idx;
         gidx_d  = pick_idx;
         hold_d  = HOLD_LOAD;
         wrote_d = 1'b0;
         state_d = ST_GRANT;
      end
   end

   // State and output registers; reset returns everything to idle at once,
   // dropping any grant in progress without counting or flagging it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         xmit_q     <= '0;
         gidx_q     <= '0;
         ptr_q      <= '0;
         hold_q     <= '0;
         wrote_q    <= 1'b0;
         last_src_q <= NO_RS;
         bcast_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         xmit_q     <= xmit_d;
         gidx_q     <= gidx_d;
         ptr_q      <= ptr_d;
         hold_q     <= hold_d;
         wrote_q    <= wrote_d;
         last_src_q <= last_src_d;
         bcast_q    <= bcast_d;
         err_q      <= err_d;
      end
   end

   assign bus.CDB_xmit    = xmit_q;
   assign bus.bus_busy    = |xmit_q;
   assign bus.grant_index = gidx_q;
   assign bus.last_source = last_src_q;
   assign bus.broadcasts  = bcast_q;
   assign bus.error       = err_q;

endmodule
